ysyx_22050078_ifu_fetch: RTL and testbench

//  Instruction fetch unit. Producer end of the 32-bit instruction interface consumed by the decoder.

---
 rtl/ysyx_22050078_ifu_fetch.sv | 168 ++++++++++++++++
 tb/tb_ysyx_22050078_ifu_fetch.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22050078_ifu_fetch.sv
// ysyx_22050078_ifu_fetch
//   Instruction fetch unit: holds the PC, issues one word fetch at a time to
//   instruction memory (req/resp), and hands {inst, pc} to the decoder over a
//   valid/ready handshake. Accepts PC redirects from the PC unit at any time.
//
// Ports
//   i_clk, i_rst           clock, synchronous active-high reset
//   o_imem_req_valid       fetch request valid (state S_REQ)
//   i_imem_req_ready       memory accepts request
//   o_imem_addr            fetch address (word aligned)
//   i_imem_resp_valid      one-cycle response strobe
//   i_imem_rdata           fetched word
//   o_inst_valid           instruction valid to decoder (state S_HOLD)
//   i_inst_ready           decoder accepts instruction
//   o_inst, o_inst_pc      instruction and its PC
//   i_redirect_valid/_pc   PC redirect; target low two bits forced to 0
//   o_fetch_timeout        sticky: a response took longer than TIMEOUT cycles
//
// Optional feature macro: YSYX_22050078_IFU_PERF_EN
//   Adds o_perf_fetch_cnt, o_perf_stall_cnt, o_perf_flush_cnt.

module ysyx_22050078_ifu_fetch #(
    parameter int                   PC_WIDTH   = 64,
    parameter int                   INST_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]  RESET_PC   = 64'h80000000,
    parameter int                   TIMEOUT    = 255
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    output logic                  o_imem_req_valid,
    input  logic                  i_imem_req_ready,
    output logic [PC_WIDTH-1:0]   o_imem_addr,
    input  logic                  i_imem_resp_valid,
    input  logic [INST_WIDTH-1:0] i_imem_rdata,
    output logic                  o_inst_valid,
    input  logic                  i_inst_ready,
    output logic [INST_WIDTH-1:0] o_inst,
    output logic [PC_WIDTH-1:0]   o_inst_pc,
    input  logic                  i_redirect_valid,
    input  logic [PC_WIDTH-1:0]   i_redirect_pc,
    output logic                  o_fetch_timeout
`ifdef YSYX_22050078_IFU_PERF_EN
   ,output logic [63:0]           o_perf_fetch_cnt,
    output logic [63:0]           o_perf_stall_cnt,
    output logic [31:0]           o_perf_flush_cnt
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_e;

    state_e                  state_q;
    logic [PC_WIDTH-1:0]     pc_q;
    logic                    drop_q;      // word in flight belongs to a squashed path
    logic [7:0]              tmo_cnt_q;
    logic [INST_WIDTH-1:0]   inst_q;
    logic [PC_WIDTH-1:0]     inst_pc_q;
    logic                    timeout_q;

    logic [PC_WIDTH-1:0]     redir_tgt;
    logic [PC_WIDTH-1:0]     pc_inc;

    assign redir_tgt = i_redirect_pc & ~PC_WIDTH'(3);
    assign pc_inc    = pc_q + PC_WIDTH'(4);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            drop_q    <= 1'b0;
            tmo_cnt_q <= 8'd0;
            inst_q    <= '0;
            inst_pc_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_q <= S_REQ;
                    if (i_redirect_valid) pc_q <= redir_tgt;
                end
                S_REQ: begin
                    if (i_redirect_valid) pc_q <= redir_tgt;
                    if (i_imem_req_ready) begin
                        state_q   <= S_WAIT;
                        tmo_cnt_q <= 8'd0;
                        // old address already accepted: its word must be dropped
                        drop_q    <= i_redirect_valid;
                    end
                end
                S_WAIT: begin
                    if (tmo_cnt_q != 8'hFF) tmo_cnt_q <= tmo_cnt_q + 8'd1;
                    if (tmo_cnt_q == 8'(TIMEOUT)) timeout_q <= 1'b1;
                    if (i_redirect_valid) begin
                        pc_q <= redir_tgt;
                        if (i_imem_resp_valid) begin
                            // response lands together with the redirect: discard now
                            drop_q  <= 1'b0;
                            state_q <= S_REQ;
                        end else begin
                            drop_q  <= 1'b1;
                        end
                    end else if (i_imem_resp_valid) begin
                        if (drop_q) begin
                            drop_q  <= 1'b0;
                            state_q <= S_REQ;
                        end else begin
                            inst_q    <= i_imem_rdata;
                            inst_pc_q <= pc_q;
                            state_q   <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (i_redirect_valid) begin
                        pc_q    <= redir_tgt;
                        state_q <= S_REQ;
                    end else if (i_inst_ready) begin
                        pc_q    <= pc_inc;
                        state_q <= S_REQ;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_imem_req_valid = (state_q == S_REQ);
    assign o_imem_addr      = pc_q;
    assign o_inst_valid     = (state_q == S_HOLD);
    assign o_inst           = inst_q;
    assign o_inst_pc        = inst_pc_q;
    assign o_fetch_timeout  = timeout_q;

`ifdef YSYX_22050078_IFU_PERF_EN
    logic [63:0] perf_fetch_q;
    logic [63:0] perf_stall_q;
    logic [31:0] perf_flush_q;
    logic        flush_ev;

    // A redirect costs a word when one is in flight (and not already doomed)
    // or when it flushes an unconsumed held instruction.
    assign flush_ev = i_redirect_valid &&
                      (((state_q == S_REQ)  && i_imem_req_ready) ||
                       ((state_q == S_WAIT) && !drop_q) ||
                       ((state_q == S_HOLD) && !i_inst_ready));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            perf_fetch_q <= 64'd0;
            perf_stall_q <= 64'd0;
            perf_flush_q <= 32'd0;
        end else begin
            if ((state_q == S_HOLD) && i_inst_ready)
                perf_fetch_q <= perf_fetch_q + 64'd1;
            if ((state_q == S_WAIT) || ((state_q == S_HOLD) && !i_inst_ready))
                perf_stall_q <= perf_stall_q + 64'd1;
            if (flush_ev)
                perf_flush_q <= perf_flush_q + 32'd1;
        end
    end

    assign o_perf_fetch_cnt = perf_fetch_q;
    assign o_perf_stall_cnt = perf_stall_q;
    assign o_perf_flush_cnt = perf_flush_q;
`else
    // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_ysyx_22050078_ifu_fetch.sv
module tb_ysyx_22050078_ifu_fetch;
    localparam logic [63:0] RST_PC = 64'h80000000;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        o_imem_req_valid;
    logic        i_imem_req_ready = 1'b0;
    logic [63:0] o_imem_addr;
    logic        i_imem_resp_valid = 1'b0;
    logic [31:0] i_imem_rdata = 32'h0;
    logic        o_inst_valid;
    logic        i_inst_ready = 1'b0;
    logic [31:0] o_inst;
    logic [63:0] o_inst_pc;
    logic        i_redirect_valid = 1'b0;
    logic [63:0] i_redirect_pc = 64'h0;
    logic        o_fetch_timeout;
`ifdef YSYX_22050078_IFU_PERF_EN
    logic [63:0] o_perf_fetch_cnt;
    logic [63:0] o_perf_stall_cnt;
    logic [31:0] o_perf_flush_cnt;
`endif

    always #5 i_clk = ~i_clk;

    ysyx_22050078_ifu_fetch dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .o_imem_req_valid(o_imem_req_valid), .i_imem_req_ready(i_imem_req_ready),
        .o_imem_addr(o_imem_addr), .i_imem_resp_valid(i_imem_resp_valid),
        .i_imem_rdata(i_imem_rdata), .o_inst_valid(o_inst_valid),
        .i_inst_ready(i_inst_ready), .o_inst(o_inst), .o_inst_pc(o_inst_pc),
        .i_redirect_valid(i_redirect_valid), .i_redirect_pc(i_redirect_pc),
        .o_fetch_timeout(o_fetch_timeout)
`ifdef YSYX_22050078_IFU_PERF_EN
       ,.o_perf_fetch_cnt(o_perf_fetch_cnt), .o_perf_stall_cnt(o_perf_stall_cnt),
        .o_perf_flush_cnt(o_perf_flush_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // memory model knobs and state
    bit          mem_on = 1'b1;
    bit          mem_fixed = 1'b0;
    logic [31:0] fixed_word = 32'h0;
    bit          rand_rdy = 1'b0;
    bit          rand_lat = 1'b0;
    int          lat = 0;
    bit          pend = 1'b0;
    int          pend_cnt = 0;
    logic [63:0] pend_addr = 64'h0;

    // reference model: program-order PC of the next instruction to be consumed
    logic [63:0] exp_pc = RST_PC;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
        logic [63:0] exp_pc;
        logic [31:0] exp_inst;
        int          cyc;
    } dlv_t;
    dlv_t        dlv_q[$];
    logic [63:0] req_q[$];

    function automatic logic [31:0] word_of(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h13579BDF;
    endfunction

    // Drive one cycle's inputs (memory + model bookkeeping), then advance to next negedge.
    task automatic step(input bit rdy, input bit redir, input logic [63:0] rpc);
        i_inst_ready      = rdy;
        i_redirect_valid  = redir;
        i_redirect_pc     = rpc;
        i_imem_resp_valid = 1'b0;
        if (i_rst) pend = 1'b0;
        else if (pend) begin
            if (pend_cnt == 0) begin
                if (mem_on) begin
                    i_imem_resp_valid = 1'b1;
                    i_imem_rdata = mem_fixed ? fixed_word : word_of(pend_addr);
                    pend = 1'b0;
                end
            end else pend_cnt--;
        end
        i_imem_req_ready = !pend && (!rand_rdy || $urandom_range(1) == 1);
        if (!i_rst && o_imem_req_valid && i_imem_req_ready) begin
            pend      = 1'b1;
            pend_addr = o_imem_addr;
            pend_cnt  = rand_lat ? int'($urandom_range(3)) : lat;
            req_q.push_back(o_imem_addr);
        end
        if (!i_rst && o_inst_valid && rdy) begin
            dlv_q.push_back('{o_inst_pc, o_inst, exp_pc,
                              mem_fixed ? fixed_word : word_of(exp_pc), cyc});
            exp_pc = exp_pc + 64'd4;
        end
        if (redir) exp_pc = rpc & ~64'h3;
        if (i_rst) exp_pc = RST_PC;
        @(negedge i_clk);
        cyc++;
    endtask

    task automatic apply_reset();
        i_rst = 1'b1;
        repeat (2) step(0, 0, 64'h0);
        i_rst = 1'b0;
        step(0, 0, 64'h0);
        dlv_q.delete();
        req_q.delete();
        mem_on = 1'b1; mem_fixed = 1'b0; rand_rdy = 1'b0; rand_lat = 1'b0; lat = 0;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 64'h0);
            checks++;
            if ({o_imem_req_valid, o_inst_valid, o_inst, o_inst_pc, o_fetch_timeout} !== '0) begin
                errors++;
                $display("FAIL reset_outputs cyc%0d got req=%b vld=%b inst=%h pc=%h tmo=%b exp all 0",
                         i, o_imem_req_valid, o_inst_valid, o_inst, o_inst_pc, o_fetch_timeout);
            end
        end
        i_rst = 1'b0;
        step(0, 0, 64'h0);
        checks++;
        if (!(o_imem_req_valid === 1'b1 && o_imem_addr === RST_PC && o_inst_valid === 1'b0)) begin
            errors++;
            $display("FAIL reset_release got req=%b addr=%h vld=%b exp req=1 addr=%h vld=0",
                     o_imem_req_valid, o_imem_addr, o_inst_valid, RST_PC);
        end
    endtask

    task automatic test_straight();
        mem_fixed = 1'b1; fixed_word = 32'h00000013; lat = 0; rand_rdy = 1'b0;
        dlv_q.delete();
        repeat (12) step(1, 0, 64'h0);
        checks++;
        if (dlv_q.size() < 3) begin
            errors++;
            $display("FAIL straight_count got %0d exp >=3", dlv_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (dlv_q[i].pc !== RST_PC + 64'(4 * i) || dlv_q[i].inst !== 32'h00000013) begin
                    errors++;
                    $display("FAIL straight_item%0d got pc=%h inst=%h exp pc=%h inst=00000013",
                             i, dlv_q[i].pc, dlv_q[i].inst, RST_PC + 64'(4 * i));
                end
            end
            for (int i = 1; i < 3; i++) begin
                checks++;
                if (dlv_q[i].cyc - dlv_q[i-1].cyc != 3) begin
                    errors++;
                    $display("FAIL straight_rate got %0d cycles exp 3", dlv_q[i].cyc - dlv_q[i-1].cyc);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        mem_fixed = 1'b1; fixed_word = 32'h00100093;
        for (int i = 0; i < 20 && o_inst_valid !== 1'b1; i++) step(0, 0, 64'h0);
        checks++;
        if (o_inst_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_reach_hold got vld=%b exp 1", o_inst_valid);
        end
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 64'h0);
            checks++;
            if (!(o_inst_valid === 1'b1 && o_inst === 32'h00100093 &&
                  o_inst_pc === RST_PC && o_imem_req_valid === 1'b0)) begin
                errors++;
                $display("FAIL bp_hold%0d got vld=%b inst=%h pc=%h req=%b exp 1/00100093/%h/0",
                         i, o_inst_valid, o_inst, o_inst_pc, o_imem_req_valid, RST_PC);
            end
        end
        step(1, 0, 64'h0);
        checks++;
        if (!(dlv_q.size() == 1 && o_imem_req_valid === 1'b1 && o_imem_addr === RST_PC + 64'd4)) begin
            errors++;
            $display("FAIL bp_release got n=%0d req=%b addr=%h exp n=1 req=1 addr=%h",
                     dlv_q.size(), o_imem_req_valid, o_imem_addr, RST_PC + 64'd4);
        end
    endtask

    task automatic test_redirect_wait();
        apply_reset();
        mem_fixed = 1'b1; fixed_word = 32'hDEADBEEF; lat = 2;
        step(1, 0, 64'h0);                       // request handshake
        step(1, 1, 64'h80000103);                // redirect while waiting
        checks++;
        if (o_inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL rw_wait_vld got %b exp 0", o_inst_valid);
        end
        step(1, 0, 64'h0);
        step(1, 0, 64'h0);                       // stale response arrives here
        checks++;
        if (!(o_inst_valid === 1'b0 && o_imem_req_valid === 1'b1 &&
              o_imem_addr === 64'h80000100 && dlv_q.size() == 0)) begin
            errors++;
            $display("FAIL rw_after_drop got vld=%b req=%b addr=%h n=%0d exp 0/1/80000100/0",
                     o_inst_valid, o_imem_req_valid, o_imem_addr, dlv_q.size());
        end
        lat = 0;
        for (int i = 0; i < 10 && dlv_q.size() == 0; i++) step(1, 0, 64'h0);
        checks++;
        if (dlv_q.size() == 0 || dlv_q[0].pc !== 64'h80000100 || dlv_q[0].inst !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL rw_deliver got n=%0d pc=%h exp pc=80000100",
                     dlv_q.size(), dlv_q.size() ? dlv_q[0].pc : 64'h0);
        end
    endtask

    task automatic test_redirect_hold();
`ifdef YSYX_22050078_IFU_PERF_EN
        logic [63:0] f0;
        logic [31:0] fl0;
`endif
        apply_reset();
        for (int i = 0; i < 20 && o_inst_valid !== 1'b1; i++) step(0, 0, 64'h0);
`ifdef YSYX_22050078_IFU_PERF_EN
        f0 = o_perf_fetch_cnt; fl0 = o_perf_flush_cnt;
`endif
        step(1, 1, 64'h80000200);
        checks++;
        if (!(dlv_q.size() == 1 && dlv_q[0].pc === RST_PC && dlv_q[0].inst === word_of(RST_PC))) begin
            errors++;
            $display("FAIL rh_consumed got n=%0d exp 1 item at %h", dlv_q.size(), RST_PC);
        end
        checks++;
        if (!(o_imem_req_valid === 1'b1 && o_imem_addr === 64'h80000200)) begin
            errors++;
            $display("FAIL rh_next_addr got req=%b addr=%h exp 1/80000200", o_imem_req_valid, o_imem_addr);
        end
`ifdef YSYX_22050078_IFU_PERF_EN
        checks++;
        if (o_perf_fetch_cnt !== f0 + 64'd1 || o_perf_flush_cnt !== fl0) begin
            errors++;
            $display("FAIL rh_perf got fetch=%0d flush=%0d exp %0d/%0d",
                     o_perf_fetch_cnt, o_perf_flush_cnt, f0 + 64'd1, fl0);
        end
`endif
    endtask

    task automatic test_timeout_wrap();
        apply_reset();
        mem_on = 1'b0;
        step(1, 0, 64'h0);
        repeat (200) step(1, 0, 64'h0);
        checks++;
        if (o_fetch_timeout !== 1'b0) begin
            errors++;
            $display("FAIL tmo_early got %b exp 0", o_fetch_timeout);
        end
        repeat (100) step(1, 0, 64'h0);
        checks++;
        if (o_fetch_timeout !== 1'b1 || o_inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL tmo_set got tmo=%b vld=%b exp 1/0", o_fetch_timeout, o_inst_valid);
        end
        mem_on = 1'b1;
        for (int i = 0; i < 10 && dlv_q.size() == 0; i++) step(1, 0, 64'h0);
        checks++;
        if (o_fetch_timeout !== 1'b1 || dlv_q.size() == 0 || dlv_q[0].pc !== RST_PC) begin
            errors++;
            $display("FAIL tmo_sticky got tmo=%b n=%0d exp tmo=1 n=1", o_fetch_timeout, dlv_q.size());
        end
        apply_reset();
        checks++;
        if (o_fetch_timeout !== 1'b0) begin
            errors++;
            $display("FAIL tmo_clear got %b exp 0", o_fetch_timeout);
        end
        // wrap: redirect to the top word, consume it, next fetch must be address 0
        step(0, 1, 64'hFFFFFFFFFFFFFFFF);
        for (int i = 0; i < 20 && dlv_q.size() == 0; i++) step(1, 0, 64'h0);
        checks++;
        if (dlv_q.size() == 0 || dlv_q[0].pc !== 64'hFFFFFFFFFFFFFFFC ||
            o_imem_req_valid !== 1'b1 || o_imem_addr !== 64'h0) begin
            errors++;
            $display("FAIL wrap got n=%0d req=%b addr=%h exp n=1 pc=fffffffffffffffc next addr 0",
                     dlv_q.size(), o_imem_req_valid, o_imem_addr);
        end
    endtask

    task automatic test_random();
        bit          r, rd, stall;
        logic [63:0] t, pp;
        logic [31:0] pi;
        int          bad;
        apply_reset();
        rand_rdy = 1'b1; rand_lat = 1'b1;
        bad = 0;
        for (int n = 0; n < 3000; n++) begin
            r  = ($urandom_range(3) != 0);
            rd = ($urandom_range(11) == 0);
            t  = {$urandom, $urandom};
            pi = o_inst; pp = o_inst_pc;
            stall = (o_inst_valid === 1'b1) && !r && !rd;
            step(r, rd, t);
            if (stall) begin
                checks++;
                if (!(o_inst_valid === 1'b1 && o_inst === pi && o_inst_pc === pp)) begin
                    errors++;
                    if (bad++ < 10)
                        $display("FAIL rand_hold_stable got vld=%b inst=%h pc=%h exp 1/%h/%h",
                                 o_inst_valid, o_inst, o_inst_pc, pi, pp);
                end
            end
            if (o_imem_req_valid === 1'b1) begin
                checks++;
                if (o_imem_addr[1:0] !== 2'b00) begin
                    errors++;
                    if (bad++ < 10) $display("FAIL rand_align got addr=%h exp low bits 00", o_imem_addr);
                end
            end
        end
        checks++;
        if (dlv_q.size() < 100) begin
            errors++;
            $display("FAIL rand_progress got %0d deliveries exp >=100", dlv_q.size());
        end
        foreach (dlv_q[i]) begin
            checks++;
            if (dlv_q[i].pc !== dlv_q[i].exp_pc || dlv_q[i].inst !== dlv_q[i].exp_inst) begin
                errors++;
                if (bad++ < 10)
                    $display("FAIL rand_stream%0d got pc=%h inst=%h exp pc=%h inst=%h", i,
                             dlv_q[i].pc, dlv_q[i].inst, dlv_q[i].exp_pc, dlv_q[i].exp_inst);
            end
        end
    endtask

    initial begin
        @(negedge i_clk);
        test_reset();
        test_straight();
        test_backpressure();
        test_redirect_wait();
        test_redirect_hold();
        test_timeout_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
